pc_next_unit: RTL and testbench

Parametrised program-counter unit for the multicycle CPU. It generalises the fixed 4-bit/28-bit jump-address concatenation into a configurable-width jump-region combine. It also owns the PC register, next-PC selection (sequential, branch, jump, register jump, return, exception) and a small return-address stack (RAS). It sits between the control FSM and the instruction-memory address port, and replaces the separate PC register and jump-combine glue.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/ras_stack.sv | 77 +++++++
 rtl/pc_next_unit.sv | 132 +++++++++++++
 tb/tb_pc_next_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC source encodings and default vectors.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_pkg;

    // Next-PC source select; codes 6 and 7 fall back to sequential.
    typedef enum logic [2:0] {
        PCSEL_SEQ    = 3'd0,
        PCSEL_BRANCH = 3'd1,
        PCSEL_JUMP   = 3'd2,
        PCSEL_JREG   = 3'd3,
        PCSEL_RET    = 3'd4,
        PCSEL_EXC    = 3'd5
    } pc_sel_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular storage with a saturating occupancy count.
// Latency: push/pop take effect at the clock edge; top/empty/full reflect state after it.
// Backpressure: none; a push when full overwrites the oldest entry.
module ras_stack #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;      // next free slot; top lives one below
    logic [CNT_W-1:0] r_count;
    logic             r_empty;
    logic             r_full;

    logic [PTR_W-1:0] w_top_idx;
    logic             w_do_pop;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_top_idx = r_ptr - PTR_W'(1);
    assign w_do_pop  = pop && (r_count != '0);
    assign top       = r_mem[w_top_idx];
    assign empty     = r_empty;
    assign full      = r_full;

    // Occupancy after this edge: push saturates, pop decrements, both cancel.
    always_comb begin
        w_count_nxt = r_count;
        if (push && !w_do_pop && (r_count != CNT_MAX)) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_do_pop && !push) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Pointer, count and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (push && !w_do_pop) begin
                r_ptr <= r_ptr + PTR_W'(1);
            end else if (w_do_pop && !push) begin
                r_ptr <= w_top_idx;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CNT_MAX);
        end
    end

    // Entry storage; push+pop rewrites the current top in place.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            if (w_do_pop) begin
                r_mem[w_top_idx] <= push_data;
            end else begin
                r_mem[r_ptr] <= push_data;
            end
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Program counter, next-PC selection, jump-region combine and return-address stack.
// Latency: 1 cycle from accepted update to new pc; pc_plus4/jdata combinational from pc.
// Backpressure: none; updates happen only on pc_write or pc_cond with zero set.
module pc_next_unit
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter int                 TARGET_W  = 26,
    parameter int                 RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_VEC = DEF_RESET_VEC,
    parameter logic [ADDR_W-1:0]  EXC_VEC   = DEF_EXC_VEC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_write,
    input  logic                pc_cond,
    input  logic                zero,
    input  logic [2:0]          pc_sel,
    input  logic                link,
    input  logic [15:0]         imm16,
    input  logic [TARGET_W-1:0] target,
    input  logic [ADDR_W-1:0]   reg_addr,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_plus4,
    output logic [ADDR_W-1:0]   jdata,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                ras_miss,
    output logic                misalign
);
    logic [ADDR_W-1:0] r_pc;
    logic              r_ras_miss;
    logic              r_misalign;

    logic              w_upd;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_push;
    logic              w_pop;
    logic              w_miss;
    logic              w_mis;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_ras_empty;

    assign w_upd    = pc_write | (pc_cond & zero);
    assign pc_plus4 = r_pc + ADDR_W'(4);
    // Word offset scaled to bytes and sign-extended to the address width.
    assign w_br_off = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
    // Jump keeps the region bits of the (possibly wrapped) sequential address.
    assign jdata    = {pc_plus4[ADDR_W-1:TARGET_W+2], target, 2'b00};

    assign pc        = r_pc;
    assign ras_miss  = r_ras_miss;
    assign misalign  = r_misalign;
    assign ras_empty = w_ras_empty;

    // Next-PC source mux, RAS control and fault detection for an accepted update.
    always_comb begin
        w_next_pc = pc_plus4;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_miss    = 1'b0;
        w_mis     = 1'b0;
        case (pc_sel)
            PCSEL_BRANCH: w_next_pc = pc_plus4 + w_br_off;
            PCSEL_JUMP: begin
                w_next_pc = jdata;
                w_push    = link;
            end
            PCSEL_JREG: begin
                w_push = link;
                if (reg_addr[1:0] != 2'b00) begin
                    w_next_pc = EXC_VEC;
                    w_mis     = 1'b1;
                end else begin
                    w_next_pc = reg_addr;
                end
            end
            PCSEL_RET: begin
                if (!w_ras_empty) begin
                    w_next_pc = w_ras_top;
                    w_pop     = 1'b1;
                end else begin
                    w_miss = 1'b1;
                    if (reg_addr[1:0] != 2'b00) begin
                        w_next_pc = EXC_VEC;
                        w_mis     = 1'b1;
                    end else begin
                        w_next_pc = reg_addr;
                    end
                end
            end
            PCSEL_EXC: w_next_pc = EXC_VEC;
            default:   w_next_pc = pc_plus4;
        endcase
        if (!w_upd) begin
            w_next_pc = r_pc;
            w_push    = 1'b0;
            w_pop     = 1'b0;
            w_miss    = 1'b0;
            w_mis     = 1'b0;
        end
    end

    // PC register and one-cycle fault pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_VEC;
            r_ras_miss <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_next_pc;
            r_ras_miss <= w_miss;
            r_misalign <= w_mis;
        end
    end

    ras_stack #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (pc_plus4),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .full      (ras_full)
    );

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit with a scoreboard of expected post-edge state.
// Latency: expectations are pushed when stimulus is applied, popped one cycle later.
// Backpressure: not applicable.
module tb_pc_next_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write, pc_cond, zero, link;
    logic [2:0]  pc_sel;
    logic [15:0] imm16;
    logic [25:0] target;
    logic [31:0] reg_addr;
    logic [31:0] pc, pc_plus4, jdata;
    logic        ras_empty, ras_full, ras_miss, misalign;

    typedef struct {
        logic [31:0] pc;
        logic        empty;
        logic        full;
        logic        miss;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pc_next_unit dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .pc_cond(pc_cond), .zero(zero),
        .pc_sel(pc_sel), .link(link), .imm16(imm16), .target(target), .reg_addr(reg_addr),
        .pc(pc), .pc_plus4(pc_plus4), .jdata(jdata), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_miss(ras_miss), .misalign(misalign)
    );

    // Applies one cycle of stimulus, advances the reference model and queues the expectation.
    task automatic drive(input logic r, input logic w, input logic c, input logic z,
                         input logic [2:0] sel, input logic lnk, input logic [15:0] imm,
                         input logic [25:0] tgt, input logic [31:0] ra);
        exp_t        e;
        logic [31:0] p4;
        logic        do_push;
        rst = r; pc_write = w; pc_cond = c; zero = z; pc_sel = sel;
        link = lnk; imm16 = imm; target = tgt; reg_addr = ra;
        e.miss = 1'b0; e.mis = 1'b0; do_push = 1'b0;
        p4 = m_pc + 32'd4;
        if (r) begin
            m_pc = 32'h0;
            m_ras.delete();
        end else if (w || (c && z)) begin
            case (sel)
                3'd1: m_pc = p4 + {{14{imm[15]}}, imm, 2'b00};
                3'd2: begin m_pc = {p4[31:28], tgt, 2'b00}; do_push = lnk; end
                3'd3: begin
                    do_push = lnk;
                    if (ra[1:0] != 2'b00) begin m_pc = 32'h180; e.mis = 1'b1; end
                    else m_pc = ra;
                end
                3'd4: begin
                    if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                    else begin
                        e.miss = 1'b1;
                        if (ra[1:0] != 2'b00) begin m_pc = 32'h180; e.mis = 1'b1; end
                        else m_pc = ra;
                    end
                end
                3'd5: m_pc = 32'h180;
                default: m_pc = p4;
            endcase
            if (do_push) begin
                m_ras.push_back(p4);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
        end
        e.pc = m_pc;
        e.empty = (m_ras.size() == 0);
        e.full  = (m_ras.size() == 4);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        drive(1, 0, 0, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0);
        e = sb.pop_front();
        checks++;
        if ({pc, ras_empty, ras_full, ras_miss, misalign} !== {e.pc, e.empty, e.full, e.miss, e.mis}) begin
            errors++;
            $display("FAIL reset: got pc=%h e=%b f=%b m=%b a=%b want pc=%h e=%b f=%b m=%b a=%b",
                     pc, ras_empty, ras_full, ras_miss, misalign, e.pc, e.empty, e.full, e.miss, e.mis);
        end
        checks++;
        if (pc_plus4 !== 32'h4) begin
            errors++;
            $display("FAIL reset_plus4: got %h want 00000004", pc_plus4);
        end
    endtask

    task automatic test_seq();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0);
            e = sb.pop_front();
            checks++;
            if ({pc, ras_empty, ras_miss, misalign} !== {e.pc, e.empty, e.miss, e.mis}) begin
                errors++;
                $display("FAIL seq%0d: got pc=%h empty=%b want pc=%h empty=%b", i, pc, ras_empty, e.pc, e.empty);
            end
        end
        checks++;
        if (pc !== 32'hC) begin
            errors++;
            $display("FAIL seq_final: got %h want 0000000c", pc);
        end
    endtask

    task automatic test_branch();
        exp_t e;
        drive(0, 1, 0, 0, 3'd3, 0, 16'h0, 26'h0, 32'h0040_0010);
        void'(sb.pop_front());
        // zero=1 takes the branch, zero=0 must leave the pc alone
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, (i == 0), 3'd1, 1, 16'hFFFE, 26'h0, 32'h0);
            e = sb.pop_front();
            checks++;
            if ({pc, ras_empty, ras_miss, misalign} !== {e.pc, e.empty, e.miss, e.mis}
                || pc !== 32'h0040_000C) begin
                errors++;
                $display("FAIL branch%0d: got pc=%h empty=%b want pc=%h (0040000c) empty=%b",
                         i, pc, ras_empty, e.pc, e.empty);
            end
        end
    endtask

    task automatic test_jump_ret();
        exp_t e;
        drive(0, 1, 0, 0, 3'd3, 0, 16'h0, 26'h0, 32'h1000_0000);
        void'(sb.pop_front());
        target = 26'h100;
        #1;
        checks++;
        if (jdata !== 32'h1000_0400) begin
            errors++;
            $display("FAIL jdata: got %h want 10000400", jdata);
        end
        drive(0, 1, 0, 0, 3'd2, 1, 16'h0, 26'h100, 32'h0);
        e = sb.pop_front();
        checks++;
        if ({pc, ras_empty, ras_full} !== {e.pc, e.empty, e.full} || pc !== 32'h1000_0400) begin
            errors++;
            $display("FAIL jump_link: got pc=%h empty=%b want pc=%h empty=%b", pc, ras_empty, e.pc, e.empty);
        end
        drive(0, 1, 0, 0, 3'd4, 0, 16'h0, 26'h0, 32'h0);
        e = sb.pop_front();
        checks++;
        if ({pc, ras_empty, ras_miss} !== {e.pc, e.empty, e.miss} || pc !== 32'h1000_0004) begin
            errors++;
            $display("FAIL ret: got pc=%h empty=%b miss=%b want pc=%h empty=%b miss=%b",
                     pc, ras_empty, ras_miss, e.pc, e.empty, e.miss);
        end
    endtask

    task automatic test_ras_overflow();
        exp_t e;
        for (int i = 1; i <= 5; i++) begin
            drive(0, 1, 0, 0, 3'd2, 1, 16'h0, 26'(i * 16), 32'h0);
            e = sb.pop_front();
            checks++;
            if ({pc, ras_empty, ras_full} !== {e.pc, e.empty, e.full}) begin
                errors++;
                $display("FAIL push%0d: got pc=%h empty=%b full=%b want pc=%h empty=%b full=%b",
                         i, pc, ras_empty, ras_full, e.pc, e.empty, e.full);
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0, 3'd4, 0, 16'h0, 26'h0, 32'h2000_0000);
            e = sb.pop_front();
            checks++;
            if ({pc, ras_empty, ras_full, ras_miss, misalign} !== {e.pc, e.empty, e.full, e.miss, e.mis}) begin
                errors++;
                $display("FAIL pop%0d: got pc=%h e=%b f=%b miss=%b want pc=%h e=%b f=%b miss=%b",
                         i, pc, ras_empty, ras_full, ras_miss, e.pc, e.empty, e.full, e.miss);
            end
        end
        // miss pulse must last exactly one cycle
        drive(0, 0, 1, 0, 3'd4, 0, 16'h0, 26'h0, 32'h0);
        e = sb.pop_front();
        checks++;
        if ({pc, ras_miss} !== {e.pc, e.miss} || ras_miss !== 1'b0) begin
            errors++;
            $display("FAIL miss_clear: got pc=%h miss=%b want pc=%h miss=0", pc, ras_miss, e.pc);
        end
    endtask

    task automatic test_misalign();
        exp_t e;
        drive(0, 1, 0, 0, 3'd3, 1, 16'h0, 26'h0, 32'h0040_0002);
        e = sb.pop_front();
        checks++;
        if ({pc, misalign, ras_empty} !== {e.pc, e.mis, e.empty} || pc !== 32'h180) begin
            errors++;
            $display("FAIL misalign: got pc=%h mis=%b empty=%b want pc=%h mis=%b empty=%b",
                     pc, misalign, ras_empty, e.pc, e.mis, e.empty);
        end
        drive(0, 1, 1, 1, 3'd6, 0, 16'h0, 26'h0, 32'h0);
        e = sb.pop_front();
        checks++;
        if ({pc, misalign} !== {e.pc, e.mis}) begin
            errors++;
            $display("FAIL mis_clear_sel6: got pc=%h mis=%b want pc=%h mis=%b", pc, misalign, e.pc, e.mis);
        end
        drive(0, 1, 0, 0, 3'd5, 0, 16'h0, 26'h0, 32'h0);
        e = sb.pop_front();
        checks++;
        if (pc !== e.pc) begin
            errors++;
            $display("FAIL exc: got pc=%h want %h", pc, e.pc);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        drive(0, 1, 0, 0, 3'd3, 0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        void'(sb.pop_front());
        target = 26'h3;
        #1;
        checks++;
        if ({pc_plus4, jdata} !== {32'h0, 32'h0000_000C}) begin
            errors++;
            $display("FAIL wrap_comb: got p4=%h jdata=%h want 00000000 0000000c", pc_plus4, jdata);
        end
        drive(0, 1, 0, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0);
        e = sb.pop_front();
        checks++;
        if (pc !== e.pc) begin
            errors++;
            $display("FAIL wrap_seq: got pc=%h want %h", pc, e.pc);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        drive(0, 1, 0, 0, 3'd2, 1, 16'h0, 26'h40, 32'h0);
        void'(sb.pop_front());
        drive(1, 1, 0, 0, 3'd2, 1, 16'h0, 26'h80, 32'h0);
        e = sb.pop_front();
        checks++;
        if ({pc, ras_empty, ras_full, ras_miss, misalign} !== {e.pc, e.empty, e.full, e.miss, e.mis}) begin
            errors++;
            $display("FAIL reset_mid: got pc=%h e=%b f=%b m=%b a=%b want pc=%h e=%b f=%b m=%b a=%b",
                     pc, ras_empty, ras_full, ras_miss, misalign, e.pc, e.empty, e.full, e.miss, e.mis);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom),
                  26'($urandom), {30'($urandom), 2'($urandom_range(0, 3) == 0 ? 1 : 0)});
            e = sb.pop_front();
            checks++;
            if ({pc, ras_empty, ras_full, ras_miss, misalign} !== {e.pc, e.empty, e.full, e.miss, e.mis}) begin
                errors++;
                $display("FAIL rand%0d: got pc=%h e=%b f=%b m=%b a=%b want pc=%h e=%b f=%b m=%b a=%b",
                         i, pc, ras_empty, ras_full, ras_miss, misalign, e.pc, e.empty, e.full, e.miss, e.mis);
            end
        end
    endtask

    initial begin
        m_pc = 32'h0;
        rst = 1'b1; pc_write = 1'b0; pc_cond = 1'b0; zero = 1'b0; link = 1'b0;
        pc_sel = 3'd0; imm16 = 16'h0; target = 26'h0; reg_addr = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_seq();
        test_branch();
        test_jump_ret();
        test_ras_overflow();
        test_misalign();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
